// File: rtl/cla32_operand_loader.sv
// Byte-serial operand loader for a 32-bit carry-lookahead adder: collects four
// bytes of A, four bytes of B plus a carry-in, then holds the set until consumed.
module cla32_operand_loader #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_ci,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_ci,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  cnt_r, cnt_s;
    logic [1:0]  lane_s;
    logic [31:0] a_r, a_s;
    logic [31:0] b_r, b_s;
    logic        ci_r, ci_s;
    logic        valid_r, valid_s;
    logic        in_ready_s;
    logic        accept_s;

    // Reset must drop ready in the same cycle, so ready is decoded rather than registered.
    always_comb begin
        in_ready_s = (state_r != HOLD) && !reset;
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state, byte placement and handshake decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        ci_s    = ci_r;
        valid_s = valid_r;
        // MSB-first placement simply mirrors the byte lane.
        lane_s  = LSB_FIRST ? cnt_r : ~cnt_r;
        case (state_r)
            LOAD_A: begin
                if (accept_s) begin
                    a_s[{lane_s, 3'b000} +: 8] = in_data;
                    if (cnt_r == 2'd3) begin
                        state_s = LOAD_B;
                        cnt_s   = 2'd0;
                    end else begin
                        cnt_s = cnt_r + 2'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            LOAD_B: begin
                if (accept_s) begin
                    b_s[{lane_s, 3'b000} +: 8] = in_data;
                    if (cnt_r == 2'd3) begin
                        ci_s    = in_ci;
                        valid_s = 1'b1;
                        state_s = HOLD;
                        cnt_s   = 2'd0;
                    end else begin
                        cnt_s = cnt_r + 2'd1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_s = 1'b0;
                    state_s = LOAD_A;
                    cnt_s   = 2'd0;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = LOAD_A;
                cnt_s   = 2'd0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and operand registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LOAD_A;
            cnt_r   <= 2'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            ci_r    <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            ci_r    <= ci_s;
            valid_r <= valid_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_a     = a_r;
    assign out_b     = b_r;
    assign out_ci    = ci_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_cla32_operand_loader.sv
// Directed bench for cla32_operand_loader: an LSB-first and an MSB-first instance
// share stimulus and are checked against a byte-queue model every cycle.
module tb_cla32_operand_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ci = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready1, in_ready0;
    logic [31:0] out_a1, out_b1, out_a0, out_b0;
    logic        out_ci1, out_ci0, out_valid1, out_valid0;

    int n_checks = 0;
    int n_err = 0;
    logic chk_on = 1'b0;

    // Model state
    logic [7:0]  q[$];
    logic        m_hold = 1'b0;
    logic [31:0] m_a1 = 32'd0, m_b1 = 32'd0, m_a0 = 32'd0, m_b0 = 32'd0;
    logic        m_ci = 1'b0;

    // Hand-computed pins for the current cycle
    logic        pin_vr = 1'b0, pin_valid = 1'b0, pin_ready = 1'b0;
    logic        pin_ops = 1'b0, pin_aa = 1'b0;
    logic [31:0] pin_a1 = 32'd0, pin_b1 = 32'd0, pin_a0 = 32'd0, pin_b0 = 32'd0;
    logic        pin_ci = 1'b0;
    logic [32:0] pin_sum = 33'd0;

    always #5 clk = ~clk;

    cla32_operand_loader #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ci(in_ci), .out_a(out_a1), .out_b(out_b1),
        .out_ci(out_ci1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    cla32_operand_loader #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ci(in_ci), .out_a(out_a0), .out_b(out_b0),
        .out_ci(out_ci0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    // Model: accumulate accepted bytes, build operands arithmetically once eight arrive.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            q.push_back(in_data);
            if (q.size() == 8) begin
                m_a1 = 32'd0; m_b1 = 32'd0; m_a0 = 32'd0; m_b0 = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    m_a1 = m_a1 | (32'(q[k])     << (8 * k));
                    m_b1 = m_b1 | (32'(q[k + 4]) << (8 * k));
                    m_a0 = m_a0 | (32'(q[k])     << (24 - 8 * k));
                    m_b0 = m_b0 | (32'(q[k + 4]) << (24 - 8 * k));
                end
                m_ci   = in_ci;
                m_hold = 1'b1;
                q.delete();
            end
        end
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process, clear of the rising edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("in_ready1", {32'd0, in_ready1}, {32'd0, !m_hold && !reset});
            check("in_ready0", {32'd0, in_ready0}, {32'd0, !m_hold && !reset});
            check("out_valid1", {32'd0, out_valid1}, {32'd0, m_hold});
            check("out_valid0", {32'd0, out_valid0}, {32'd0, m_hold});
            if (m_hold) begin
                check("model_a1", {1'b0, out_a1}, {1'b0, m_a1});
                check("model_b1", {1'b0, out_b1}, {1'b0, m_b1});
                check("model_a0", {1'b0, out_a0}, {1'b0, m_a0});
                check("model_b0", {1'b0, out_b0}, {1'b0, m_b0});
                check("model_ci1", {32'd0, out_ci1}, {32'd0, m_ci});
                check("model_ci0", {32'd0, out_ci0}, {32'd0, m_ci});
            end
            if (pin_vr) begin
                check("pin_valid", {32'd0, out_valid1}, {32'd0, pin_valid});
                check("pin_ready", {32'd0, in_ready1}, {32'd0, pin_ready});
            end
            if (pin_ops) begin
                check("pin_a1", {1'b0, out_a1}, {1'b0, pin_a1});
                check("pin_b1", {1'b0, out_b1}, {1'b0, pin_b1});
                check("pin_a0", {1'b0, out_a0}, {1'b0, pin_a0});
                check("pin_b0", {1'b0, out_b0}, {1'b0, pin_b0});
                check("pin_ci", {32'd0, out_ci1}, {32'd0, pin_ci});
                check("pin_sum", {1'b0, out_a1} + {1'b0, out_b1} + {32'd0, out_ci1}, pin_sum);
            end
            if (pin_aa) begin
                check("aa_lsb", {25'd0, out_a1[7:0]}, 33'h0AA);
                check("aa_msb", {25'd0, out_a0[31:24]}, 33'h0AA);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pin_vr = 1'b0; pin_ops = 1'b0; pin_aa = 1'b0;
    endtask

    task automatic set_vr(input logic v, input logic r);
        pin_vr = 1'b1; pin_valid = v; pin_ready = r;
    endtask

    task automatic set_ops(input logic [31:0] a1, input logic [31:0] b1, input logic ci,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [32:0] sum);
        pin_ops = 1'b1; pin_a1 = a1; pin_b1 = b1; pin_ci = ci;
        pin_a0 = a0; pin_b0 = b0; pin_sum = sum;
    endtask

    task automatic beat(input logic [7:0] d, input logic ci);
        in_valid = 1'b1; in_data = d; in_ci = ci;
        tick();
        in_valid = 1'b0; in_ci = 1'b0;
    endtask

    // Eight beats, first byte in v[63:56]; optional 1-3 idle cycles between beats.
    task automatic load8(input logic [63:0] v, input logic ci, input logic gaps);
        for (int k = 0; k < 8; k++) begin
            beat(v[63 - 8 * k -: 8], (k == 7) ? ci : 1'b0);
            if (gaps && k < 7) begin
                int n;
                n = int'($urandom_range(3, 1));
                for (int g = 0; g < n; g++) tick();
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        chk_on = 1'b1;
        set_vr(1'b0, 1'b0);
        set_ops(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 33'd0);
        tick();
        reset = 1'b0;
        set_vr(1'b0, 1'b1);
        set_ops(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 33'd0);
        tick();

        // Back-to-back set, single-cycle out_valid
        load8(64'h78563412_01000000, 1'b0, 1'b0);
        set_vr(1'b1, 1'b0);
        set_ops(32'h12345678, 32'h00000001, 1'b0, 32'h78563412, 32'h01000000, 33'h0_12345679);
        tick();
        set_vr(1'b0, 1'b1);
        tick();

        // Same data with idle gaps
        load8(64'h78563412_01000000, 1'b0, 1'b1);
        set_vr(1'b1, 1'b0);
        set_ops(32'h12345678, 32'h00000001, 1'b0, 32'h78563412, 32'h01000000, 33'h0_12345679);
        tick();
        set_vr(1'b0, 1'b1);
        tick();

        // Back-pressure in HOLD with AA pending on the input
        out_ready = 1'b0;
        load8(64'h11223344_55667788, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            set_vr(1'b1, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        set_vr(1'b1, 1'b0);
        tick();
        set_vr(1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        pin_aa = 1'b1;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);

        // Reset after five accepted beats, then a carry-out set
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_vr(1'b0, 1'b1);
        set_ops(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 33'd0);
        tick();
        load8(64'hFFFFFFFF_00000000, 1'b1, 1'b0);
        set_vr(1'b1, 1'b0);
        set_ops(32'hFFFFFFFF, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h0, 33'h1_00000000);
        tick();
        tick();

        // MSB-first placement
        load8(64'h12345678_DEADBEEF, 1'b0, 1'b0);
        set_vr(1'b1, 1'b0);
        set_ops(32'h78563412, 32'hEFBEADDE, 1'b0, 32'h12345678, 32'hDEADBEEF, 33'h1_6814E1F0);
        tick();
        tick();

        // Reset coincident with the 8th beat
        for (int k = 0; k < 7; k++) beat(8'h5A, 1'b0);
        in_valid = 1'b1; in_data = 8'hC3; in_ci = 1'b1; reset = 1'b1;
        tick();
        in_valid = 1'b0; in_ci = 1'b0; reset = 1'b0;
        set_vr(1'b0, 1'b1);
        set_ops(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 33'd0);
        tick();
        load8(64'h01020304_05060708, 1'b0, 1'b0);
        set_vr(1'b1, 1'b0);
        set_ops(32'h04030201, 32'h08070605, 1'b0, 32'h01020304, 32'h05060708, 33'h0_0C0A0806);
        tick();
        tick();

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cla32_operand_loader.md
CLA32_OPERAND_LOADER -- requirements
Module: cla32_operand_loader

Interface
- REQ-001: Parameter LSB_FIRST, default 1; 1 = first byte of each operand lands in bits [7:0], 0 = first byte lands in bits [31:24].
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: in_valid  input  1  byte beat on in_data is valid.
- REQ-005: in_ready  output  1  loader can accept a byte this cycle.
- REQ-006: in_data  input  8  operand byte.
- REQ-007: in_ci  input  1  carry-in; sampled only on the 8th accepted beat.
- REQ-008: out_a  output  32  assembled operand A, to adder input a.
- REQ-009: out_b  output  32  assembled operand B, to adder input b.
- REQ-010: out_ci  output  1  captured carry-in, to adder input ci.
- REQ-011: out_valid  output  1  out_a, out_b and out_ci form a complete operand set.
- REQ-012: out_ready  input  1  downstream consumer accepts the operand set.

Function
- REQ-013: A beat SHALL be accepted when in_valid and in_ready are both high at a rising edge.
- REQ-014: The FSM SHALL have three states: LOAD_A, LOAD_B and HOLD, plus a 2-bit beat counter.
- REQ-015: In LOAD_A, accepted beat k (k = 0..3) SHALL write in_data to out_a[8k+7:8k] when LSB_FIRST=1, and to out_a[31-8k:24-8k] when LSB_FIRST=0.
- REQ-016: In LOAD_B, the byte placement SHALL be the same as REQ-015 but targets out_b.
- REQ-017: The 4th accepted beat SHALL move LOAD_A to LOAD_B and reset the counter to 0.
- REQ-018: The 4th accepted beat in LOAD_B SHALL capture in_ci into out_ci, move the FSM to HOLD, and set out_valid high in the next cycle.
- REQ-019: in_ready SHALL be high in LOAD_A and LOAD_B, and low in HOLD and whenever reset is high.
- REQ-020: Cycles with in_valid low SHALL leave the state, the counter and all outputs unchanged; no timeout applies.
- REQ-021: In HOLD, out_a, out_b, out_ci and out_valid SHALL stay stable until out_ready is high at a rising edge.
- REQ-022: out_valid and out_ready both high at an edge SHALL clear out_valid in the next cycle and move the FSM to LOAD_A with counter 0.
- REQ-023: out_a and out_b SHALL NOT be cleared between operations; bytes are overwritten in place and are meaningful only while out_valid is high.
- REQ-024: The minimum period SHALL be 9 cycles per operand set: 8 beats plus 1 HOLD cycle. No overlap of the next load with HOLD.
- REQ-025: out_valid SHALL rise exactly 1 cycle after the 8th accepted beat.
- REQ-026: out_ready SHALL be ignored outside HOLD.

Reset
- REQ-027: While reset is high at an edge, the block SHALL set state=LOAD_A, counter=0, out_a=0, out_b=0, out_ci=0 and out_valid=0.
- REQ-028: Reset SHALL take priority over any simultaneous beat or out_ready handshake.
- REQ-029: Reset mid-load or in HOLD SHALL discard all partial or held data.
- REQ-030: in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
- REQ-031: LSB_FIRST=1, out_ready=1. Drive A bytes 78,56,34,12 and B bytes 01,00,00,00, with in_ci=0 on the last beat. Required: out_a=0x12345678, out_b=0x00000001 and out_ci=0; out_valid is high for exactly one cycle, one cycle after beat 8.
- REQ-032: Same data as REQ-031 with in_valid low for 1-3 random cycles between beats. Required: identical outputs; out_valid rises 1 cycle after the last beat.
- REQ-033: Complete a set with out_ready=0 for 5 cycles while in_valid is held high with byte AA. Required: in_ready=0, no beat consumed and outputs stable. Then out_ready=1; required: out_valid=0 next cycle, and byte AA is accepted as A byte 0 in that cycle.
- REQ-034: Assert reset for 1 cycle after 5 accepted beats. Required: all outputs 0 and in_ready=1 after release. A fresh 8 beats FF×4, 00×4 with in_ci=1 then give out_a=0xFFFFFFFF, out_b=0 and out_ci=1, so the downstream sum is 0x00000000 with co=1.
- REQ-035: LSB_FIRST=0. Drive A bytes 12,34,56,78 and B bytes DE,AD,BE,EF. Required: out_a=0x12345678 and out_b=0xDEADBEEF.
- REQ-036: Assert reset at the same edge as the 8th beat. Required: out_valid stays 0 and state=LOAD_A.
